id_operand_stage: RTL and testbench

Decode-side operand stage that feeds the execute stage. It holds the 32×32 general register file and resolves two source operands, applying EX-stage and write-back forwarding and an immediate override. It then registers the operands together with the decoded ALU control into the ID/EX pipeline register. Its outputs drive execute's aluop/alusel/regOp1/regOp2/dest_addr/write_or_not inputs directly. Execute's result triple (dest, write-enable, data) returns here as the EX forwarding source.

---
 rtl/id_operand_stage_pkg.sv | 31 +++
 rtl/id_operand_stage_regfile.sv | 49 ++++
 rtl/id_operand_stage.sv | 110 +++++++++++
 tb/tb_id_operand_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : id_operand_stage_pkg
// Purpose : Shared operator codes (the defineOperator set) and register-file
//           geometry for the decode operand stage and the execute stage.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
package id_operand_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // ALU operation codes
  localparam logic [7:0] ALUOP_NOP = 8'h00;
  localparam logic [7:0] ALUOP_AND = 8'h24;
  localparam logic [7:0] ALUOP_OR  = 8'h25;
  localparam logic [7:0] ALUOP_XOR = 8'h26;
  localparam logic [7:0] ALUOP_ADD = 8'h20;
  localparam logic [7:0] ALUOP_SUB = 8'h22;

  // Result class codes
  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
  localparam logic [2:0] ALUSEL_ARITH = 3'b100;

  // Architectural zero register index
  localparam int REG_ZERO = 0;

endpackage : id_operand_stage_pkg
`default_nettype wire

// File: rtl/id_operand_stage_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : id_operand_stage_regfile
// Purpose : General register file, 2 combinational read ports, 1 synchronous
//           write port, register 0 hardwired to zero, synchronous clear.
//           No forwarding here; the stage above handles bypassing.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module id_operand_stage_regfile
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem [NREGS];

  // Synchronous clear on rst; writes to the zero register are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != ZERO_ADDR)) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational reads; register 0 always reads zero
  always_comb begin
    rdata1 = (raddr1 == ZERO_ADDR) ? '0 : mem[raddr1];
    rdata2 = (raddr2 == ZERO_ADDR) ? '0 : mem[raddr2];
  end

endmodule : id_operand_stage_regfile
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : id_operand_stage
// Purpose : Decode operand stage. Reads two source operands, bypasses from
//           execute (newest) and write-back, applies the immediate override
//           and registers operands plus ALU control into the ID/EX register.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_en,
  input  logic              rs2_en,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic [7:0]        aluop_in,
  input  logic [2:0]        alusel_in,
  input  logic [ADDR_W-1:0] dest_addr_in,
  input  logic              write_in,
  input  logic [ADDR_W-1:0] ex_dest_addr,
  input  logic              ex_write,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_we,
  input  logic [DATA_W-1:0] wb_data,
  output logic [7:0]        aluop_out,
  output logic [2:0]        alusel_out,
  output logic [DATA_W-1:0] op1_out,
  output logic [DATA_W-1:0] op2_out,
  output logic [ADDR_W-1:0] dest_addr_out,
  output logic              write_out
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [DATA_W-1:0] op1_res;
  logic [DATA_W-1:0] op2_res;
  logic [DATA_W-1:0] op2_sel;

  id_operand_stage_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1_addr),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2_addr),
    .rdata2 (rf_rdata2),
    .waddr  (wb_addr),
    .we     (wb_we),
    .wdata  (wb_data)
  );

  // Operand resolution: zero cases, then EX bypass, then WB write-through, then array
  always_comb begin
    op1_res = rf_rdata1;
    if (rst || !rs1_en || (rs1_addr == ZERO_ADDR)) begin
      op1_res = '0;
    end else if (ex_write && (ex_dest_addr == rs1_addr)) begin
      op1_res = ex_wdata;
    end else if (wb_we && (wb_addr == rs1_addr)) begin
      op1_res = wb_data;
    end

    op2_res = rf_rdata2;
    if (rst || !rs2_en || (rs2_addr == ZERO_ADDR)) begin
      op2_res = '0;
    end else if (ex_write && (ex_dest_addr == rs2_addr)) begin
      op2_res = ex_wdata;
    end else if (wb_we && (wb_addr == rs2_addr)) begin
      op2_res = wb_data;
    end

    // The immediate overrides operand 2 regardless of rs2_en
    op2_sel = use_imm ? imm : op2_res;
  end

  // ID/EX register: reset, then bubble on flush, then hold on stall, else load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      aluop_out     <= ALUOP_NOP;
      alusel_out    <= ALUSEL_NOP;
      op1_out       <= '0;
      op2_out       <= '0;
      dest_addr_out <= '0;
      write_out     <= 1'b0;
    end else if (!stall) begin
      aluop_out     <= aluop_in;
      alusel_out    <= alusel_in;
      op1_out       <= op1_res;
      op2_out       <= op2_sel;
      dest_addr_out <= dest_addr_in;
      write_out     <= write_in;
    end
  end

endmodule : id_operand_stage
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_id_operand_stage
// Purpose : Directed self-checking bench for id_operand_stage.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst, stall, flush;
  logic [ADDR_W-1:0] rs1_addr, rs2_addr;
  logic              rs1_en, rs2_en, use_imm;
  logic [DATA_W-1:0] imm;
  logic [7:0]        aluop_in;
  logic [2:0]        alusel_in;
  logic [ADDR_W-1:0] dest_addr_in;
  logic              write_in;
  logic [ADDR_W-1:0] ex_dest_addr;
  logic              ex_write;
  logic [DATA_W-1:0] ex_wdata;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;
  logic [7:0]        aluop_out;
  logic [2:0]        alusel_out;
  logic [DATA_W-1:0] op1_out, op2_out;
  logic [ADDR_W-1:0] dest_addr_out;
  logic              write_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_operand_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_en        (rs1_en),
    .rs2_en        (rs2_en),
    .use_imm       (use_imm),
    .imm           (imm),
    .aluop_in      (aluop_in),
    .alusel_in     (alusel_in),
    .dest_addr_in  (dest_addr_in),
    .write_in      (write_in),
    .ex_dest_addr  (ex_dest_addr),
    .ex_write      (ex_write),
    .ex_wdata      (ex_wdata),
    .wb_addr       (wb_addr),
    .wb_we         (wb_we),
    .wb_data       (wb_data),
    .aluop_out     (aluop_out),
    .alusel_out    (alusel_out),
    .op1_out       (op1_out),
    .op2_out       (op2_out),
    .dest_addr_out (dest_addr_out),
    .write_out     (write_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] aop, input logic [2:0] asel,
                           input logic [31:0] o1, input logic [31:0] o2,
                           input logic [4:0] dst, input logic wr);
    check({tag, ".aluop"},  32'(aluop_out), 32'(aop));
    check({tag, ".alusel"}, 32'(alusel_out), 32'(asel));
    check({tag, ".op1"},    op1_out, o1);
    check({tag, ".op2"},    op2_out, o2);
    check({tag, ".dest"},   32'(dest_addr_out), 32'(dst));
    check({tag, ".write"},  32'(write_out), 32'(wr));
  endtask

  task automatic set_instr(input logic [4:0] r1, input logic [4:0] r2,
                           input logic [7:0] aop, input logic [2:0] asel,
                           input logic [4:0] dst, input logic wr);
    rs1_addr = r1; rs2_addr = r2; rs1_en = 1'b1; rs2_en = 1'b1;
    aluop_in = aop; alusel_in = asel; dest_addr_in = dst; write_in = wr;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rs1_en = 1'b0; rs2_en = 1'b0;
    use_imm = 1'b0; imm = '0;
    aluop_in = ALUOP_ADD; alusel_in = ALUSEL_ARITH; dest_addr_in = 5'd4; write_in = 1'b1;
    ex_dest_addr = '0; ex_write = 1'b0; ex_wdata = '0;
    wb_addr = '0; wb_we = 1'b0; wb_data = '0;

    // Reset state
    step();
    check_all("reset", 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;

    // Write-back r3 = 0xF0, then read it
    wb_addr = 5'd3; wb_we = 1'b1; wb_data = 32'h0000_00F0;
    step();
    wb_we = 1'b0;
    set_instr(5'd3, 5'd0, ALUOP_OR, ALUSEL_LOGIC, 5'd7, 1'b1);
    step();
    check_all("rd_r3", ALUOP_OR, ALUSEL_LOGIC, 32'h0000_00F0, 32'h0, 5'd7, 1'b1);

    // EX beats WB for the same register
    wb_addr = 5'd5; wb_we = 1'b1; wb_data = 32'h11;
    ex_dest_addr = 5'd5; ex_write = 1'b1; ex_wdata = 32'h22;
    set_instr(5'd5, 5'd5, ALUOP_ADD, ALUSEL_ARITH, 5'd8, 1'b1);
    step();
    check("ex_fwd.op1", op1_out, 32'h22);
    check("ex_fwd.op2", op2_out, 32'h22);
    // WB bypass alone
    ex_write = 1'b0;
    step();
    check("wb_fwd.op1", op1_out, 32'h11);
    check("wb_fwd.op2", op2_out, 32'h11);
    // Array value after the write landed
    wb_we = 1'b0;
    step();
    check("arr_r5", op1_out, 32'h11);

    // Zero register: write dropped, EX forward to r0 ignored
    wb_addr = 5'd0; wb_we = 1'b1; wb_data = 32'hDEAD;
    set_instr(5'd0, 5'd0, ALUOP_OR, ALUSEL_LOGIC, 5'd1, 1'b1);
    step();
    check("r0_wb.op1", op1_out, 32'h0);
    wb_we = 1'b0;
    ex_dest_addr = 5'd0; ex_write = 1'b1; ex_wdata = 32'hBEEF;
    step();
    check("r0_ex.op1", op1_out, 32'h0);
    ex_write = 1'b0;
    step();
    check("r0_arr.op1", op1_out, 32'h0);

    // Read enable low gives zero even for a populated register
    set_instr(5'd3, 5'd5, ALUOP_OR, ALUSEL_LOGIC, 5'd1, 1'b1);
    rs1_en = 1'b0;
    step();
    check("en0.op1", op1_out, 32'h0);
    check("en0.op2", op2_out, 32'h11);

    // Instruction A, then stall for three cycles with changing inputs
    set_instr(5'd3, 5'd5, ALUOP_ADD, ALUSEL_ARITH, 5'd9, 1'b1);
    step();
    check_all("instrA", ALUOP_ADD, ALUSEL_ARITH, 32'hF0, 32'h11, 5'd9, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(5'(10 + i), 5'd3, ALUOP_XOR, ALUSEL_LOGIC, 5'(20 + i), 1'b0);
      // register file still writes while stalled
      wb_addr = 5'd6; wb_we = 1'b1; wb_data = 32'h66 + 32'(i);
      step();
      check_all("stall", ALUOP_ADD, ALUSEL_ARITH, 32'hF0, 32'h11, 5'd9, 1'b1);
    end
    stall = 1'b0; wb_we = 1'b0;
    set_instr(5'd6, 5'd3, ALUOP_SUB, ALUSEL_ARITH, 5'd12, 1'b1);
    step();
    check_all("instrB", ALUOP_SUB, ALUSEL_ARITH, 32'h68, 32'hF0, 5'd12, 1'b1);

    // Flush wins over stall
    stall = 1'b1; flush = 1'b1;
    step();
    check_all("flush", 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    stall = 1'b0; flush = 1'b0;

    // Immediate overrides a forwarded operand 2
    set_instr(5'd5, 5'd5, ALUOP_ADD, ALUSEL_ARITH, 5'd2, 1'b1);
    ex_dest_addr = 5'd5; ex_write = 1'b1; ex_wdata = 32'h77;
    use_imm = 1'b1; imm = 32'h0000_1234; rs2_en = 1'b0;
    step();
    check("imm.op1", op1_out, 32'h77);
    check("imm.op2", op2_out, 32'h0000_1234);
    use_imm = 1'b0; ex_write = 1'b0;

    // Fill r1..r31
    for (int i = 1; i < 32; i++) begin
      wb_addr = 5'(i); wb_we = 1'b1; wb_data = 32'hA500_0000 | 32'(i);
      step();
    end
    wb_we = 1'b0;
    set_instr(5'd31, 5'd17, ALUOP_OR, ALUSEL_LOGIC, 5'd3, 1'b1);
    step();
    check("fill.op1", op1_out, 32'hA500_001F);
    check("fill.op2", op2_out, 32'hA500_0011);

    // Reset while stalled clears outputs and the array
    rst = 1'b1; stall = 1'b1;
    step();
    check_all("rst_mid", 8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0; stall = 1'b0;
    for (int i = 1; i < 32; i++) begin
      set_instr(5'(i), 5'(32 - i), ALUOP_OR, ALUSEL_LOGIC, 5'd1, 1'b1);
      step();
      check("post_rst.op1", op1_out, 32'h0);
      check("post_rst.op2", op2_out, 32'h0);
    end
    check("post_rst.aluop", 32'(aluop_out), 32'(ALUOP_OR));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_id_operand_stage
`default_nettype wire
